// File: rtl/wb_regfile.sv
// Write-back stage of the 16-bit pipeline: selects the MEM/WB result and destination,
// commits it to the register file, exposes bypassed read ports and WB forwarding info.
module wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NREG     = 16,
    parameter int LINK_REG = 15
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [1:0]        RegDst,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              run,
    input  logic              call,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] pc_addr,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] Mem_out,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted,
    output logic [15:0]       retired_count
);

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic              dest_ok;

    always_comb begin
        wb_data = call ? pc_addr : (MemtoReg ? Mem_out : ALU_result);
        wb_dest = RegDst[0] ? LINK_ADDR : Rd;
        // RegDst 10/11 are reserved encodings and never write.
        dest_ok = ~RegDst[1];
        wb_valid = RegWrite & run & ~halted & ~clear & dest_ok & (wb_dest != '0);
    end

    // Write-first bypass lets decode see the value being committed this cycle.
    always_comb begin
        ra_data = '0;
        if (ra_addr != '0)
            ra_data = (wb_valid && ra_addr == wb_dest) ? wb_data : regs[ra_addr];
    end

    always_comb begin
        rb_data = '0;
        if (rb_addr != '0)
            rb_data = (wb_valid && rb_addr == wb_dest) ? wb_data : regs[rb_addr];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            // NOTE: the architecture defines every register as 0 after clear, so the
            // array is reset here; this costs a reset mux per bit instead of a plain RAM.
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            if (wb_valid) begin
                regs[wb_dest] <= wb_data;
                if (retired_count != 16'hFFFF)
                    retired_count <= retired_count + 16'd1;
            end
            if (!run && !halted)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, bypass, link/R0 handling,
// reserved RegDst, halt, counter saturation and clear-vs-halt priority.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        clear;
    logic [1:0]  RegDst;
    logic        MemtoReg;
    logic        RegWrite;
    logic        run;
    logic        call;
    logic [3:0]  Rd;
    logic [15:0] pc_addr;
    logic [15:0] ALU_result;
    logic [15:0] Mem_out;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        halted;
    logic [15:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile dut (
        .clk          (clk),
        .clear        (clear),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .run          (run),
        .call         (call),
        .Rd           (Rd),
        .pc_addr      (pc_addr),
        .ALU_result   (ALU_result),
        .Mem_out      (Mem_out),
        .ra_addr      (ra_addr),
        .rb_addr      (rb_addr),
        .ra_data      (ra_data),
        .rb_data      (rb_data),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .halted       (halted),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge before the next step.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b1; RegDst = 2'b00; MemtoReg = 1'b0; RegWrite = 1'b0;
        run = 1'b1; call = 1'b0; Rd = 4'd0; pc_addr = '0; ALU_result = '0;
        Mem_out = '0; ra_addr = '0; rb_addr = '0;
        tick();
        clear = 1'b0;
        #1;

        // Reset state: every register reads 0 on both ports.
        for (int a = 0; a < 16; a++) begin
            ra_addr = 4'(a);
            rb_addr = 4'(15 - a);
            #1;
            check($sformatf("reset_ra_r%0d", a), ra_data, 16'h0000);
            check($sformatf("reset_rb_r%0d", 15 - a), rb_data, 16'h0000);
        end
        check("reset_halted", {15'b0, halted}, 16'h0000);
        check("reset_count", retired_count, 16'h0000);

        // Plain ALU write to R3 with same-cycle bypass on both ports.
        RegWrite = 1'b1; RegDst = 2'b00; Rd = 4'd3; MemtoReg = 1'b0; ALU_result = 16'h1234;
        ra_addr = 4'd3; rb_addr = 4'd3;
        #1;
        check("bypass_ra", ra_data, 16'h1234);
        check("bypass_rb", rb_data, 16'h1234);
        check("bypass_valid", {15'b0, wb_valid}, 16'h0001);
        check("bypass_dest", {12'b0, wb_dest}, 16'h0003);
        tick();
        RegWrite = 1'b0; ALU_result = 16'h0000;
        #1;
        check("r3_stored", ra_data, 16'h1234);
        check("count_after_r3", retired_count, 16'h0001);

        // CALL writes the link register regardless of Rd.
        call = 1'b1; RegDst = 2'b01; pc_addr = 16'h00A2; RegWrite = 1'b1; Rd = 4'd9;
        #1;
        check("call_dest", {12'b0, wb_dest}, 16'h000F);
        check("call_data", wb_data, 16'h00A2);
        tick();
        // Load aimed at R0 is dropped, but forwarding data still reflects the select.
        call = 1'b0; RegDst = 2'b00; MemtoReg = 1'b1; Mem_out = 16'hBEEF; Rd = 4'd0;
        ra_addr = 4'd0; rb_addr = 4'd15;
        #1;
        check("r0_write_valid", {15'b0, wb_valid}, 16'h0000);
        check("r0_fwd_data", wb_data, 16'hBEEF);
        check("r15_link", rb_data, 16'h00A2);
        check("r0_bypass_blocked", ra_data, 16'h0000);
        tick();
        check("r0_after", ra_data, 16'h0000);
        check("count_after_r0", retired_count, 16'h0002);

        // Reserved RegDst encoding never writes.
        RegDst = 2'b10; MemtoReg = 1'b0; Rd = 4'd5; ALU_result = 16'h5555; ra_addr = 4'd5;
        #1;
        check("rsvd_valid", {15'b0, wb_valid}, 16'h0000);
        tick();
        RegDst = 2'b11;
        #1;
        check("rsvd11_valid", {15'b0, wb_valid}, 16'h0000);
        tick();
        check("rsvd_r5", ra_data, 16'h0000);
        check("rsvd_count", retired_count, 16'h0002);

        // Halt instruction does not write and sets the sticky flag.
        RegDst = 2'b00; run = 1'b0; Rd = 4'd6; ALU_result = 16'h7777; ra_addr = 4'd6;
        #1;
        check("halt_instr_valid", {15'b0, wb_valid}, 16'h0000);
        tick();
        run = 1'b1;
        #1;
        check("halt_r6", ra_data, 16'h0000);
        check("halted_set", {15'b0, halted}, 16'h0001);
        Rd = 4'd7; ALU_result = 16'h0707; ra_addr = 4'd7;
        #1;
        check("halted_valid", {15'b0, wb_valid}, 16'h0000);
        tick();
        tick();
        check("halted_r7", ra_data, 16'h0000);
        check("halted_sticky", {15'b0, halted}, 16'h0001);
        check("halted_count", retired_count, 16'h0002);

        // Clear with a write in flight: write discarded, state wiped.
        clear = 1'b1;
        #1;
        check("clear_valid", {15'b0, wb_valid}, 16'h0000);
        tick();
        clear = 1'b0; RegWrite = 1'b0; ra_addr = 4'd3; rb_addr = 4'd15;
        #1;
        check("clear_halted", {15'b0, halted}, 16'h0000);
        check("clear_r3", ra_data, 16'h0000);
        check("clear_r15", rb_data, 16'h0000);
        check("clear_r7", dut.regs[7], 16'h0000);
        check("clear_count", retired_count, 16'h0000);

        // Counter saturation: 65534 writes to R1, then three more.
        RegWrite = 1'b1; Rd = 4'd1; ra_addr = 4'd1;
        for (int i = 0; i < 65534; i++) begin
            ALU_result = 16'(i);
            tick();
        end
        RegWrite = 1'b0;
        #1;
        check("count_fffe", retired_count, 16'hFFFE);
        check("r1_last", ra_data, 16'hFFFD);
        RegWrite = 1'b1;
        ALU_result = 16'hA001; tick();
        check("count_ffff", retired_count, 16'hFFFF);
        ALU_result = 16'hA002; tick();
        ALU_result = 16'hA003; tick();
        RegWrite = 1'b0;
        #1;
        check("count_sat", retired_count, 16'hFFFF);
        check("r1_after_sat", ra_data, 16'hA003);

        // Simultaneous clear and halt: clear wins.
        clear = 1'b1; run = 1'b0; RegWrite = 1'b1; Rd = 4'd2; ALU_result = 16'h2222;
        ra_addr = 4'd2;
        tick();
        clear = 1'b0; run = 1'b1; RegWrite = 1'b0;
        #1;
        check("clr_run_halted", {15'b0, halted}, 16'h0000);
        check("clr_run_r2", ra_data, 16'h0000);
        check("clr_run_count", retired_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface in the 16-bit pipelined computer: consumes the MEM/WB register outputs, selects the write-back value and destination, and commits it to a 16-entry register file.
- Provides two decode-stage read ports with same-cycle write bypass.
- Exports the WB-stage forwarding triple to the data-forwarding unit.
- Latches the halt condition and counts committed register writes.

Parameters:
DATA_W, 16, datapath and register width
ADDR_W, 4, register address width
NREG, 16, number of registers (2**ADDR_W)
LINK_REG, 15, destination for RegDst=01 (CALL return address)

Ports:
clk  input  1  clock, all state updates on posedge
clear  input  1  synchronous active-high reset
RegDst  input  2  destination select from MEM/WB
MemtoReg  input  1  1: write Mem_out, 0: write ALU_result
RegWrite  input  1  register write request
run  input  1  0 marks halt instruction
call  input  1  1: write pc_addr (link value)
Rd  input  ADDR_W  destination register field
pc_addr  input  DATA_W  return address for CALL
ALU_result  input  DATA_W  ALU result
Mem_out  input  DATA_W  load data
ra_addr  input  ADDR_W  read port A address
rb_addr  input  ADDR_W  read port B address
ra_data  output  DATA_W  read port A data
rb_data  output  DATA_W  read port B data
wb_valid  output  1  WB stage commits a write this cycle
wb_dest  output  ADDR_W  WB destination register
wb_data  output  DATA_W  WB write value
halted  output  1  sticky halt flag
retired_count  output  16  committed-write counter

Behaviour:
- Reset (clear=1 at posedge):
  - all registers become 0; halted=0; retired_count=0.
  - No write commits in a cycle where clear=1, regardless of inputs.
- Value select (combinational):
  - call=1 selects pc_addr.
  - Otherwise MemtoReg=1 selects Mem_out, else ALU_result.
- Destination (combinational):
  - RegDst=00 selects Rd; RegDst=01 selects LINK_REG.
  - RegDst=10/11 are reserved: no write.
- Write enable: wb_valid = RegWrite & run & ~halted & ~clear & (RegDst is 00 or 01) & (dest != 0).
  - R0 reads as 0 at all times; writes to R0 are dropped and wb_valid=0.
- Commit: when wb_valid=1, regs[wb_dest] <= wb_data at posedge. Write latency is 1 cycle.
- Read ports are combinational:
  - If address is 0, output 0.
  - Else if wb_valid and address == wb_dest, output wb_data (write-first bypass).
  - Else output the stored register.
  - A and B are independent; both may hit the bypass at once.
- Forwarding outputs:
  - wb_dest and wb_data always reflect the current select logic.
  - Consumers qualify them with wb_valid.
- Halt:
  - When run=0 and halted=0 and clear=0, halted <= 1 at posedge.
  - The halt instruction itself never writes, even if RegWrite=1.
  - halted stays 1 until clear; while halted, all writes are suppressed and retired_count is frozen.
- retired_count increments by 1 on each posedge with wb_valid=1 and saturates at 0xFFFF (no wrap).
- Simultaneous clear and run=0: clear wins; halted=0.
- A clear mid-stream discards the in-flight write that cycle.

Test Plan:
- Reset then read all addresses -> ra_data=rb_data=0x0000, halted=0, retired_count=0.
- RegWrite=1, RegDst=00, Rd=3, MemtoReg=0, ALU_result=0x1234 -> same cycle ra_addr=3 gives 0x1234 via bypass and wb_valid=1; next cycle, with RegWrite=0, ra_data=0x1234; retired_count=1.
- call=1, RegDst=01, pc_addr=0x00A2, RegWrite=1 -> R15=0x00A2. Then MemtoReg=1, Mem_out=0xBEEF, Rd=0 -> R0 still 0, wb_valid=0, count unchanged.
- RegDst=10, RegWrite=1, Rd=5 -> no write, wb_valid=0. Next, run=0 with RegWrite=1, Rd=6, ALU_result=0x7777 -> R6 unchanged, halted=1 next cycle. Following writes to R7 are ignored until clear, after which halted=0 and all registers read 0.
- Preload retired_count to 0xFFFE via repeated writes, then perform 3 more writes -> count reads 0xFFFF and holds.
- clear=1 and run=0 in the same cycle with RegWrite=1, Rd=2 -> halted=0, R2=0, count=0.
